// File: rtl/uart_cfg_pkg.sv
// Shared types and helpers for the runtime-configurable UART.
package uart_cfg_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE3 = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic [1:0] data_bits;
        parity_t    parity;
        logic       stop2;
    } frame_cfg_t;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_word_t;

    function automatic logic [3:0] nbits(input logic [1:0] db);
        return 4'd5 + 4'(db);
    endfunction

    function automatic logic par_en(input parity_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Even parity over the low n bits; odd is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic [3:0] n,
                                        input parity_t mode);
        logic [7:0] mask;
        logic       p;
        mask = 8'hFF >> (4'd8 - n);
        p    = ^(data & mask);
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO; a write while full is accepted if a read happens in the same cycle.
module fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] r_data
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic                  do_rd, do_wr;

    assign empty  = (w_ptr_q == r_ptr_q);
    assign full   = (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]) &&
                    (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]);
    assign r_data = mem_q[r_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        do_rd   = rd & ~empty;
        do_wr   = wr & (~full | do_rd);
        w_ptr_d = w_ptr_q + PW'(do_wr);
        r_ptr_d = r_ptr_q + PW'(do_rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            if (do_wr) mem_q[w_ptr_q[ADDR_WIDTH-1:0]] <= w_data;
        end
    end
endmodule

// File: rtl/uart_cfg_rx.sv
// UART receiver: oversampled FSM with per-frame config, parity and framing checks.
module uart_cfg_rx
    import uart_cfg_pkg::*;
#(
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rx,
    input  logic [1:0] data_bits,
    input  logic [1:0] parity_mode,
    output logic       push_c,
    output rx_word_t   word_c
);
    localparam int unsigned S_W    = $clog2(SB_TICK);
    localparam logic [S_W-1:0] S_HALF = S_W'(SB_TICK / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICK - 1);

    rx_state_t      state_q, state_d;
    logic [S_W-1:0] s_q, s_d;
    logic [2:0]     n_q, n_d;
    logic [7:0]     b_q, b_d;
    logic [1:0]     db_q, db_d;
    parity_t        pm_q, pm_d;
    logic           perr_q, perr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            db_q    <= '0;
            pm_q    <= PAR_NONE;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            db_q    <= db_d;
            pm_q    <= pm_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        db_d    = db_q;
        pm_d    = pm_q;
        perr_d  = perr_q;
        case (state_q)
            RX_IDLE: if (!rx) begin
                state_d = RX_START;
                s_d     = '0;
                db_d    = data_bits;
                pm_d    = parity_t'(parity_mode);
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            RX_START: if (tick) begin
                if (s_q == S_HALF) begin
                    s_d    = '0;
                    n_d    = '0;
                    b_d    = '0;
                    perr_d = 1'b0;
                    state_d = rx ? RX_IDLE : RX_DATA;
                end else s_d = s_q + S_W'(1);
            end
            RX_DATA: if (tick) begin
                if (s_q == S_LAST) begin
                    s_d      = '0;
                    b_d[n_q] = rx;
                    if (n_q == 3'(nbits(db_q) - 4'd1))
                        state_d = par_en(pm_q) ? RX_PARITY : RX_STOP;
                    else n_d = n_q + 3'd1;
                end else s_d = s_q + S_W'(1);
            end
            RX_PARITY: if (tick) begin
                if (s_q == S_LAST) begin
                    s_d     = '0;
                    perr_d  = rx ^ parity_bit(b_q, nbits(db_q), pm_q);
                    state_d = RX_STOP;
                end else s_d = s_q + S_W'(1);
            end
            RX_STOP: if (tick) begin
                if (s_q == S_LAST) state_d = RX_IDLE;
                else s_d = s_q + S_W'(1);
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        push_c      = (state_q == RX_STOP) && tick && (s_q == S_LAST);
        word_c.ferr = ~rx;
        word_c.perr = perr_q;
        word_c.data = b_q;
    end
endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: baud generator, TX FSM, RX sub-module and both FIFOs.
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned FIFO_W  = 2,
    parameter int unsigned DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_uart,
    input  logic              wr_uart,
    input  logic [7:0]        w_data,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              clr_err,
    input  logic              rx,
    output logic              tx,
    output logic              tx_full,
    output logic              rx_empty,
    output logic              tx_idle,
    output logic [7:0]        r_data,
    output logic              r_perr,
    output logic              r_ferr,
    output logic              ovr_err
);
    localparam int unsigned S2_W = $clog2(2 * SB_TICK);
    localparam logic [S2_W-1:0] S_LAST  = S2_W'(SB_TICK - 1);
    localparam logic [S2_W-1:0] S_LAST2 = S2_W'(2 * SB_TICK - 1);

    logic [DVSR_W-1:0] cnt_q, cnt_d, dvsr_q, dvsr_d;
    logic              tick_c;
    tx_state_t         tx_state_q, tx_state_d;
    logic [S2_W-1:0]   ts_q, ts_d;
    logic [2:0]        tn_q, tn_d;
    logic [7:0]        tb_q, tb_d, tx_head;
    frame_cfg_t        tcfg_q, tcfg_d;
    logic              tpar_q, tpar_d, tx_q, tx_d, ovr_q, ovr_d;
    logic              tx_pop_c, tx_load_c, tx_empty, rx_push_c, rx_full;
    rx_word_t          rx_word_c, rx_head;

    fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset(reset), .rd(tx_pop_c), .wr(wr_uart), .w_data(w_data),
        .empty(tx_empty), .full(tx_full), .r_data(tx_head)
    );

    fifo #(.DATA_WIDTH(10), .ADDR_WIDTH(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset(reset), .rd(rd_uart), .wr(rx_push_c), .w_data(rx_word_c),
        .empty(rx_empty), .full(rx_full), .r_data(rx_head)
    );

    uart_cfg_rx #(.SB_TICK(SB_TICK)) u_rx (
        .clk(clk), .reset(reset), .tick(tick_c), .rx(rx), .data_bits(data_bits),
        .parity_mode(parity_mode), .push_c(rx_push_c), .word_c(rx_word_c)
    );

    // Divisor is re-latched only at wrap so a change never truncates a tick period.
    always_comb begin
        tick_c = (cnt_q == dvsr_q);
        cnt_d  = tick_c ? '0 : cnt_q + DVSR_W'(1);
        dvsr_d = tick_c ? dvsr : dvsr_q;
        ovr_d  = (rx_push_c & rx_full & ~rd_uart) | (ovr_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            dvsr_q     <= '0;
            tx_state_q <= TX_IDLE;
            ts_q       <= '0;
            tn_q       <= '0;
            tb_q       <= '0;
            tcfg_q     <= '0;
            tpar_q     <= 1'b0;
            tx_q       <= 1'b1;
            ovr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dvsr_q     <= dvsr_d;
            tx_state_q <= tx_state_d;
            ts_q       <= ts_d;
            tn_q       <= tn_d;
            tb_q       <= tb_d;
            tcfg_q     <= tcfg_d;
            tpar_q     <= tpar_d;
            tx_q       <= tx_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        ts_d       = ts_q;
        tn_d       = tn_q;
        tb_d       = tb_q;
        tcfg_d     = tcfg_q;
        tpar_d     = tpar_q;
        tx_pop_c   = 1'b0;
        tx_load_c  = 1'b0;
        case (tx_state_q)
            TX_IDLE: tx_load_c = ~tx_empty;
            TX_START: if (tick_c) begin
                if (ts_q == S_LAST) begin
                    ts_d       = '0;
                    tn_d       = '0;
                    tx_state_d = TX_DATA;
                end else ts_d = ts_q + S2_W'(1);
            end
            TX_DATA: if (tick_c) begin
                if (ts_q == S_LAST) begin
                    ts_d = '0;
                    tb_d = tb_q >> 1;
                    if (tn_q == 3'(nbits(tcfg_q.data_bits) - 4'd1))
                        tx_state_d = par_en(tcfg_q.parity) ? TX_PARITY : TX_STOP;
                    else tn_d = tn_q + 3'd1;
                end else ts_d = ts_q + S2_W'(1);
            end
            TX_PARITY: if (tick_c) begin
                if (ts_q == S_LAST) begin
                    ts_d       = '0;
                    tx_state_d = TX_STOP;
                end else ts_d = ts_q + S2_W'(1);
            end
            // A queued word starts straight out of STOP with no idle gap.
            TX_STOP: if (tick_c) begin
                if (ts_q == (tcfg_q.stop2 ? S_LAST2 : S_LAST)) begin
                    if (tx_empty) tx_state_d = TX_IDLE;
                    else tx_load_c = 1'b1;
                end else ts_d = ts_q + S2_W'(1);
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load_c) begin
            tx_pop_c   = 1'b1;
            tx_state_d = TX_START;
            ts_d       = '0;
            tb_d       = tx_head;
            tcfg_d     = '{data_bits: data_bits, parity: parity_t'(parity_mode), stop2: stop2};
            tpar_d     = parity_bit(tx_head, nbits(data_bits), parity_t'(parity_mode));
        end
    end

    // Line level follows the state being entered, so START drives low one cycle after the pop.
    always_comb begin
        tx_d = 1'b1;
        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tb_d[0];
            TX_PARITY: tx_d = tpar_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
    assign ovr_err = ovr_q;
    assign r_data  = rx_head.data;
    assign r_perr  = rx_head.perr;
    assign r_ferr  = rx_head.ferr;
endmodule

// File: doc/uart_cfg.md
# uart_cfg

Runtime-configurable UART core. It is the parametrised successor to the fixed 8N1 UART. It adds per-frame selectable data length (5–8 bits), parity (none/even/odd) and stop length (1/2 bits). Receive errors are reported: parity and framing errors are stored per word alongside the data, and overrun is a sticky flag. It sits behind the bus-side register wrapper exactly where the fixed UART sat, and reuses the team's existing `fifo` for both buffers.

## Interface
- `SB_TICK`, 16: oversampling ticks per bit; must be even.
- `FIFO_W`, 2: FIFO address bits; depth is 2^FIFO_W.
- `DVSR_W`, 11: baud divisor width.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `rd_uart` in 1: pop the RX FIFO head; ignored when `rx_empty`.
- `wr_uart` in 1: push `w_data` into the TX FIFO; ignored (word dropped) when `tx_full`.
- `w_data` in 8: TX word; only the low N bits are sent.
- `dvsr` in DVSR_W: baud divisor; tick period is dvsr+1 clocks.
- `data_bits` in 2: 00=5, 01=6, 10=7, 11=8 data bits.
- `parity_mode` in 2: 00=none, 01=even, 10=odd, 11=none.
- `stop2` in 1: 1 = two stop bits (TX only).
- `clr_err` in 1: clears `ovr_err`.
- `rx` in 1: serial input; already synchronised upstream.
- `tx` out 1: serial output; idles at 1.
- `tx_full` out 1: TX FIFO full.
- `rx_empty` out 1: RX FIFO empty.
- `tx_idle` out 1: TX FIFO empty and TX FSM in IDLE.
- `r_data` out 8: RX FIFO head, zero-extended above N bits.
- `r_perr` out 1: parity error flag of the head word.
- `r_ferr` out 1: framing error flag of the head word.
- `ovr_err` out 1: sticky; set when a received word is dropped because the RX FIFO is full.

## Operation
- Baud generator
  - Counter 0..dvsr, wrapping.
  - One-cycle `tick` when count==dvsr.
  - `dvsr` changes take effect on the next wrap.
- Config capture
  - RX and TX each latch `data_bits`/`parity_mode`/`stop2` when leaving IDLE.
  - A config change mid-frame affects only the next frame.
- Parity
  - Even parity bit = XOR of the N data bits.
  - Odd parity bit = its inverse.
- RX FSM (IDLE, START, DATA, PARITY, STOP)
  - IDLE→START on `rx`=0.
  - START: after SB_TICK/2 ticks, sample `rx`.
    - 1 → IDLE (glitch, nothing pushed).
    - 0 → DATA.
  - DATA: sample every SB_TICK ticks, LSB first, N samples.
  - PARITY: entered only if parity is enabled; one sample, compared against the computed parity.
  - STOP: one sample after SB_TICK ticks.
    - 0 sets the framing error.
    - In either case, push {ferr, perr, data} and go to IDLE.
    - RX checks only the first stop bit regardless of `stop2`.
- RX push rules
  - Push happens in the cycle STOP completes.
  - If the RX FIFO is full, the word is dropped and `ovr_err` is set.
  - A simultaneous `rd_uart` in that cycle frees space per `fifo` semantics, and the word is accepted.
- TX FSM (IDLE, START, DATA, PARITY, STOP)
  - IDLE with TX FIFO non-empty: pop the head, latch word and config, go to START.
  - `tx` is driven low in the following cycle.
  - Bit durations:
    - START: SB_TICK ticks.
    - DATA: SB_TICK ticks per bit, LSB first, N bits.
    - PARITY: SB_TICK ticks, if enabled.
    - STOP: SB_TICK ticks, or 2×SB_TICK when `stop2`.
  - Back-to-back frames: START follows STOP with no extra idle bit.
- `clr_err` and a new overrun in the same cycle: `ovr_err` remains 1 (set wins).

## Timing
- Reset values:
  - `tx`=1, `tx_idle`=1.
  - `tx_full`=0, `rx_empty`=1.
  - `ovr_err`=0.
  - `r_data`, `r_perr`, `r_ferr` = 0.
  - Both FSMs in IDLE; baud counter 0.
- Reset asserted mid-frame: both FIFOs are emptied and `tx` returns to 1 immediately (asynchronously).
- `r_data`/`r_perr`/`r_ferr` show the FIFO head combinationally; `rd_uart` advances the head on the clock edge.
- `rx_empty` deasserts one clock after the STOP-completion push.
- TX latency: `wr_uart` at cycle 0 with FSM idle → `tx` low by cycle 2 (tick-independent start). Bit boundaries are then tick-aligned.
- Frame length in ticks = SB_TICK × (1 + N + P + S), where P = 0/1 (parity) and S = 1/2 (stop bits).

## Structure
- Package `uart_cfg_pkg` holds:
  - `parity_t` enum;
  - RX and TX state enums;
  - `nbits(data_bits)` function (returns 5..8);
  - `parity_bit(data, n, mode)` function.
- RX FIFO is `fifo` with DATA_WIDTH 10; TX FIFO is `fifo` with DATA_WIDTH 8.
- One natural sub-module: `uart_cfg_rx` (RX FSM plus error generation).
- TX FSM and baud generator are inline in `uart_cfg`.

## Test plan
All tests use dvsr=3 (4 clocks/tick, 64 clocks/bit) with `tx` looped back to `rx`.
- 8N1, write 0xA5 → `r_data`=0xA5, `r_perr`=0, `r_ferr`=0, frame lasts 640 clocks.
- 7E1, write 0xC1 → wire carries bits 1,0,0,0,0,0,1 then parity 0; `r_data`=0x41.
- 5O2, write 0x15 → parity bit 0, stop high for 128 clocks; `r_data`=0x15.
- Parity fault: 8E1 frame of 0x01 with parity forced 0 → `r_data`=0x01, `r_perr`=1. Stop forced 0 → `r_ferr`=1.
- Overrun: FIFO_W=2, receive 5 frames 0x10..0x14 without reads → the 4 reads return 0x10..0x13, `ovr_err`=1; pulse `clr_err` → 0.
- Glitch and reset:
  - `rx` low for 4 ticks → no word pushed.
  - Assert `reset` mid-TX-frame → `tx`=1 immediately, `tx_idle`=1, `rx_empty`=1.
